// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM single-port syncram arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int READ_LAT_DEF   = 1;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 4;
  localparam int LAT_CNT_W_DEF  = $clog2(READ_LAT_DEF + 1);

  // Width of a counter that must hold 0..read_lat.
  function automatic int lat_cnt_w(input int read_lat);
    return (read_lat < 1) ? 1 : $clog2(read_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester was denied; at_max
// tells the arbiter to force that requester through.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (req && !gnt) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and DM ports onto one single-ported syncram, DM first,
// with a starvation override for IF; read data is steered back by owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READ_LAT   = READ_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_cs,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int               LAT_W    = lat_cnt_w(READ_LAT);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  logic [LAT_W-1:0] lat_cnt_q;
  logic [LAT_W-1:0] lat_cnt_d;
  owner_t           owner_q;
  owner_t           owner_d;

  logic issue_open;
  logic ret_now;
  logic starve_at_max;
  logic if_win;
  logic dm_win;
  logic read_gnt;
  logic store_gnt;

  // The final return cycle also accepts a new access, so reads pipeline.
  assign issue_open = (lat_cnt_q <= LAT_ONE);
  assign ret_now    = !rst && (lat_cnt_q == LAT_ONE);

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!rst && issue_open) begin
      if (if_req && (!dm_req || starve_at_max)) begin
        if_win = 1'b1;
      end else if (dm_req) begin
        dm_win = 1'b1;
      end
    end
  end

  assign read_gnt  = if_win || (dm_win && !dm_we);
  assign store_gnt = dm_win && dm_we;

  always_comb begin
    if_gnt   = if_win;
    dm_gnt   = dm_win;
    ram_cs   = if_win || dm_win;
    ram_oe   = read_gnt;
    ram_we   = store_gnt;
    ram_addr = '0;
    ram_din  = '0;
    if (if_win) begin
      ram_addr = if_addr;
    end else if (dm_win) begin
      ram_addr = dm_addr;
    end
    if (store_gnt) begin
      ram_din = dm_wdata;
    end
  end

  always_comb begin
    if_rvalid = ret_now && (owner_q == OWN_IF);
    dm_rvalid = ret_now && (owner_q == OWN_DM);
    if_rdata  = if_rvalid ? ram_dout : '0;
    dm_rdata  = dm_rvalid ? ram_dout : '0;
  end

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    if (read_gnt) begin
      lat_cnt_d = LAT_LOAD;
      owner_d   = if_win ? OWN_IF : OWN_DM;
    end else if (store_gnt) begin
      lat_cnt_d = '0;
      owner_d   = OWN_NONE;
    end else if (lat_cnt_q != '0) begin
      lat_cnt_d = lat_cnt_q - 1'b1;
      if (lat_cnt_q == LAT_ONE) begin
        owner_d = OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q <= '0;
      owner_q   <= OWN_NONE;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
    end
  end

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .req   (if_req),
    .gnt   (if_win),
    .at_max(starve_at_max)
  );

endmodule
